// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame motion, aim and fire controller for N arena players.
// Keycode words from the keyboard front-ends are decoded against a per-player key map.
// On each frame_clk rising edge every player's position, facing, speed ramp, fire pulse
// and cooldown advance once; results appear on the outputs one Clk after the tick.
// Optional feature macro: PLAYER_COLLISION_EN (players block each other within 32 px).
module player_motion_ctrl #(
   parameter int NUM_PLAYERS   = 2,
   parameter int X_MIN         = 64,
   parameter int X_MAX         = 3136,
   parameter int Y_MIN         = 64,
   parameter int Y_MAX         = 2336,
   parameter int SPEED_MIN     = 1,
   parameter int SPEED_MAX     = 4,
   parameter int ACCEL_FRAMES  = 8,
   parameter int FIRE_COOLDOWN = 15,
   parameter logic [12*NUM_PLAYERS-1:0] INIT_X = {12'd1500, 12'd700},
   parameter logic [12*NUM_PLAYERS-1:0] INIT_Y = {12'd1400, 12'd700},
   // Per player, LSB byte first: move-N, move-W, move-S, move-E, face-N, face-S,
   // face-W, face-E, fire. Player 0 = USB HID codes, player 1 = PS/2 set-2 codes.
   parameter logic [72*NUM_PLAYERS-1:0] KEYMAP = {72'h29_74_6B_72_75_23_1B_1C_1D,
                                                 72'h2C_4F_50_51_52_07_16_04_1A}
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      frame_clk,
   input  logic [32*NUM_PLAYERS-1:0] keycode,
   output logic [12*NUM_PLAYERS-1:0] pos_x,
   output logic [12*NUM_PLAYERS-1:0] pos_y,
   output logic [2*NUM_PLAYERS-1:0]  dir,
   output logic [NUM_PLAYERS-1:0]    moving,
   output logic [4*NUM_PLAYERS-1:0]  speed,
   output logic [NUM_PLAYERS-1:0]    fire
);

   localparam logic [15:0] ACC_LAST  = 16'(ACCEL_FRAMES - 1);
   localparam logic [3:0]  SPD_MIN_V = 4'(SPEED_MIN);
   localparam logic [3:0]  SPD_MAX_V = 4'(SPEED_MAX);
   localparam logic [7:0]  CD_LOAD   = 8'(FIRE_COOLDOWN);

   // Facing codes
   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_S = 2'd1;
   localparam logic [1:0] DIR_E = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   logic                      frame_clk_q;
   logic                      tick;
   logic [9*NUM_PLAYERS-1:0]  held;
   logic [12*NUM_PLAYERS-1:0] cand_x, cand_y;
   logic [NUM_PLAYERS-1:0]    blocked;

   logic [12*NUM_PLAYERS-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [2*NUM_PLAYERS-1:0]  dir_q, dir_d;
   logic [NUM_PLAYERS-1:0]    moving_q, moving_d;
   logic [NUM_PLAYERS-1:0]    fire_q, fire_d;
   logic [4*NUM_PLAYERS-1:0]  speed_q, speed_d;
   logic [16*NUM_PLAYERS-1:0] acc_q, acc_d;
   logic [8*NUM_PLAYERS-1:0]  cool_q, cool_d;

   // A key is held when any of the four rollover slots carries its code; code 00 is unmapped.
   function automatic logic key_held(input logic [31:0] kc, input logic [7:0] code);
      key_held = (code != 8'h00) &&
                 ((kc[7:0] == code) || (kc[15:8] == code) ||
                  (kc[23:16] == code) || (kc[31:24] == code));
   endfunction

   // One axis step in 14-bit signed arithmetic, clamped so an overshoot lands on the bound.
   function automatic logic [11:0] step_clamp(input logic [11:0] pos, input logic [3:0] spd,
                                              input logic inc, input logic dec,
                                              input int lo, input int hi);
      logic signed [13:0] sum;
      logic signed [13:0] lo_s;
      logic signed [13:0] hi_s;
      lo_s = 14'(lo);
      hi_s = 14'(hi);
      sum  = signed'({2'b00, pos});
      if (inc && !dec) begin
         sum = sum + signed'({10'd0, spd});
      end else if (dec && !inc) begin
         sum = sum - signed'({10'd0, spd});
      end
      if (sum < lo_s) begin
         sum = lo_s;
      end else if (sum > hi_s) begin
         sum = hi_s;
      end
      step_clamp = sum[11:0];
   endfunction

   assign tick = frame_clk & ~frame_clk_q;

   // Decode the nine mapped keys of every player
   always_comb begin
      held = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         for (int k = 0; k < 9; k++) begin
            held[p*9+k] = key_held(keycode[p*32 +: 32], KEYMAP[p*72 + k*8 +: 8]);
         end
      end
   end

   // Candidate positions from the pre-tick speed (E/S increase, W/N decrease)
   always_comb begin
      cand_x = '0;
      cand_y = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         cand_x[p*12 +: 12] = step_clamp(pos_x_q[p*12 +: 12], speed_q[p*4 +: 4],
                                         held[p*9+3], held[p*9+1], X_MIN, X_MAX);
         cand_y[p*12 +: 12] = step_clamp(pos_y_q[p*12 +: 12], speed_q[p*4 +: 4],
                                         held[p*9+2], held[p*9+0], Y_MIN, Y_MAX);
      end
   end

`ifdef PLAYER_COLLISION_EN
   // Chebyshev distance below 32 on both axes counts as a collision.
   function automatic logic near(input logic [11:0] ax, input logic [11:0] ay,
                                 input logic [11:0] bx, input logic [11:0] by);
      logic signed [12:0] ddx;
      logic signed [12:0] ddy;
      ddx  = signed'({1'b0, ax}) - signed'({1'b0, bx});
      ddy  = signed'({1'b0, ay}) - signed'({1'b0, by});
      near = (ddx > -13'sd32) && (ddx < 13'sd32) && (ddy > -13'sd32) && (ddy < 13'sd32);
   endfunction

   // Cancel a move that lands near another player's old position or new candidate
   always_comb begin
      blocked = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         for (int q = 0; q < NUM_PLAYERS; q++) begin
            if (q != p) begin
               if (near(cand_x[p*12 +: 12], cand_y[p*12 +: 12],
                        pos_x_q[q*12 +: 12], pos_y_q[q*12 +: 12]) ||
                   near(cand_x[p*12 +: 12], cand_y[p*12 +: 12],
                        cand_x[q*12 +: 12], cand_y[q*12 +: 12])) begin
                  blocked[p] = 1'b1;
               end
            end
         end
      end
   end
`else
   assign blocked = '0;
`endif

   // Per-player next state; everything holds and fire drops unless a frame tick arrives
   always_comb begin
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      dir_d    = dir_q;
      moving_d = moving_q;
      speed_d  = speed_q;
      acc_d    = acc_q;
      cool_d   = cool_q;
      fire_d   = '0;
      if (tick) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            moving_d[p] = |held[p*9 +: 4];
            if (!blocked[p]) begin
               pos_x_d[p*12 +: 12] = cand_x[p*12 +: 12];
               pos_y_d[p*12 +: 12] = cand_y[p*12 +: 12];
            end
            // later keys in this list win
            if (held[p*9+0]) dir_d[p*2 +: 2] = DIR_N;
            if (held[p*9+1]) dir_d[p*2 +: 2] = DIR_W;
            if (held[p*9+2]) dir_d[p*2 +: 2] = DIR_S;
            if (held[p*9+3]) dir_d[p*2 +: 2] = DIR_E;
            if (held[p*9+4]) dir_d[p*2 +: 2] = DIR_N;
            if (held[p*9+5]) dir_d[p*2 +: 2] = DIR_S;
            if (held[p*9+6]) dir_d[p*2 +: 2] = DIR_W;
            if (held[p*9+7]) dir_d[p*2 +: 2] = DIR_E;
            if (!(|held[p*9 +: 4])) begin
               speed_d[p*4 +: 4]  = SPD_MIN_V;
               acc_d[p*16 +: 16]  = '0;
            end else if (acc_q[p*16 +: 16] == ACC_LAST) begin
               acc_d[p*16 +: 16]  = '0;
               speed_d[p*4 +: 4]  = (speed_q[p*4 +: 4] < SPD_MAX_V) ?
                                    speed_q[p*4 +: 4] + 4'd1 : SPD_MAX_V;
            end else begin
               acc_d[p*16 +: 16]  = acc_q[p*16 +: 16] + 16'd1;
            end
            if (held[p*9+8] && (cool_q[p*8 +: 8] == 8'd0)) begin
               fire_d[p]          = 1'b1;
               cool_d[p*8 +: 8]   = CD_LOAD;
            end else if (cool_q[p*8 +: 8] != 8'd0) begin
               cool_d[p*8 +: 8]   = cool_q[p*8 +: 8] - 8'd1;
            end
         end
      end
   end

   // State registers; reset restores the start layout and suppresses a tick at release
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_clk_q <= 1'b1;
         pos_x_q     <= INIT_X;
         pos_y_q     <= INIT_Y;
         dir_q       <= '0;
         moving_q    <= '0;
         speed_q     <= {NUM_PLAYERS{SPD_MIN_V}};
         acc_q       <= '0;
         cool_q      <= '0;
         fire_q      <= '0;
      end else begin
         frame_clk_q <= frame_clk;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         dir_q       <= dir_d;
         moving_q    <= moving_d;
         speed_q     <= speed_d;
         acc_q       <= acc_d;
         cool_q      <= cool_d;
         fire_q      <= fire_d;
      end
   end

   assign pos_x  = pos_x_q;
   assign pos_y  = pos_y_q;
   assign dir    = dir_q;
   assign moving = moving_q;
   assign speed  = speed_q;
   assign fire   = fire_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl (default parameters, two players).
module tb_player_motion_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic [63:0] keycode = '0;
   logic [23:0] pos_x, pos_y;
   logic [3:0]  dir;
   logic [1:0]  moving;
   logic [7:0]  speed;
   logic [1:0]  fire;

   player_motion_ctrl dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .keycode   (keycode),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .dir       (dir),
      .moving    (moving),
      .speed     (speed),
      .fire      (fire)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int x;
      int y;
      int spd;
   } exp_t;

   exp_t sb[$];
   bit   fire_sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_x, m_y, m_spd, m_acc;
   logic [1:0] f_now, f_after;

   // Reference model of player 0: step, clamp, speed ramp; pushes the expectation.
   task automatic model_step(input int dx, input int dy, input bit mv);
      exp_t e;
      m_x = m_x + dx * m_spd;
      m_y = m_y + dy * m_spd;
      if (m_x < 64)   m_x = 64;
      if (m_x > 3136) m_x = 3136;
      if (m_y < 64)   m_y = 64;
      if (m_y > 2336) m_y = 2336;
      if (!mv) begin
         m_spd = 1;
         m_acc = 0;
      end else if (m_acc == 7) begin
         m_acc = 0;
         if (m_spd < 4) m_spd = m_spd + 1;
      end else begin
         m_acc = m_acc + 1;
      end
      e.x = m_x; e.y = m_y; e.spd = m_spd;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_x = 700; m_y = 700; m_spd = 1; m_acc = 0;
   endtask

   // One frame: frame_clk rises for one Clk; fire sampled in the pulse cycle and the one after.
   task automatic tick_frame(output logic [1:0] fn, output logic [1:0] fa);
      @(negedge Clk);
      frame_clk = 1'b1;
      @(negedge Clk);
      fn = fire;
      frame_clk = 1'b0;
      @(negedge Clk);
      fa = fire;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      frame_clk = 1'b0;
      keycode = '0;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b1;
      keycode[31:0] = 32'h0000_0007;
      @(negedge Clk);
      Reset = 1'b0;
      repeat (10) @(negedge Clk);
      model_reset();
      n_checks++;
      if ({pos_x, pos_y} !== {12'd1500, 12'd700, 12'd1400, 12'd700}) begin
         n_errors++;
         $display("FAIL reset_pos: x=%0d,%0d y=%0d,%0d want 700,1500 / 700,1400",
                  pos_x[11:0], pos_x[23:12], pos_y[11:0], pos_y[23:12]);
      end
      n_checks++;
      if ({dir, moving, speed, fire} !== {4'd0, 2'd0, 4'd1, 4'd1, 2'd0}) begin
         n_errors++;
         $display("FAIL reset_ctrl: dir=%h moving=%b speed=%h fire=%b want 0 00 11 00",
                  dir, moving, speed, fire);
      end
      keycode = '0;
      frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_move_east();
      exp_t e;
      keycode[31:0] = 32'h0000_0007;
      for (int t = 1; t <= 20; t++) begin
         model_step(1, 0, 1);
         tick_frame(f_now, f_after);
         e = sb.pop_front();
         n_checks++;
         if ({pos_x[11:0], pos_y[11:0], speed[3:0]} !== {12'(e.x), 12'(e.y), 4'(e.spd)}) begin
            n_errors++;
            $display("FAIL east_tick%0d: x=%0d y=%0d spd=%0d want x=%0d y=%0d spd=%0d",
                     t, pos_x[11:0], pos_y[11:0], speed[3:0], e.x, e.y, e.spd);
         end
      end
      n_checks++;
      if ({pos_x[11:0], dir[1:0], moving[0], speed[3:0]} !== {12'd736, 2'd2, 1'b1, 4'd3}) begin
         n_errors++;
         $display("FAIL east_final: x=%0d dir=%0d mv=%b spd=%0d want 736 2 1 3",
                  pos_x[11:0], dir[1:0], moving[0], speed[3:0]);
      end
      keycode = '0;
      model_step(0, 0, 0);
      tick_frame(f_now, f_after);
      e = sb.pop_front();
      n_checks++;
      if ({pos_x[11:0], moving[0], speed[3:0]} !== {12'(e.x), 1'b0, 4'd1}) begin
         n_errors++;
         $display("FAIL east_release: x=%0d mv=%b spd=%0d want x=%0d mv=0 spd=1",
                  pos_x[11:0], moving[0], speed[3:0], e.x);
      end
   endtask

   task automatic test_reset_tick();
      exp_t e;
      keycode = {32'h0000_0029, 32'h0000_0007};
      for (int t = 1; t <= 3; t++) begin
         model_step(1, 0, 1);
         tick_frame(f_now, f_after);
         e = sb.pop_front();
         n_checks++;
         if ({pos_x[11:0], f_now[1]} !== {12'(e.x), (t == 1)}) begin
            n_errors++;
            $display("FAIL pre_reset_tick%0d: x=%0d fire1=%b want x=%0d fire1=%b",
                     t, pos_x[11:0], f_now[1], e.x, (t == 1));
         end
      end
      @(negedge Clk);
      frame_clk = 1'b1;
      Reset = 1'b1;
      @(negedge Clk);
      model_reset();
      n_checks++;
      if ({pos_x[11:0], pos_y[11:0], speed[3:0], moving[0], fire} !==
          {12'd700, 12'd700, 4'd1, 1'b0, 2'b00}) begin
         n_errors++;
         $display("FAIL reset_on_tick: x=%0d y=%0d spd=%0d mv=%b fire=%b want 700 700 1 0 00",
                  pos_x[11:0], pos_y[11:0], speed[3:0], moving[0], fire);
      end
      Reset = 1'b0;
      frame_clk = 1'b0;
      @(negedge Clk);
      model_step(1, 0, 1);
      tick_frame(f_now, f_after);
      e = sb.pop_front();
      n_checks++;
      if ({pos_x[11:0], f_now[1]} !== {12'(e.x), 1'b1}) begin
         n_errors++;
         $display("FAIL cooldown_cleared: x=%0d fire1=%b want x=%0d fire1=1",
                  pos_x[11:0], f_now[1], e.x);
      end
      keycode = '0;
      model_step(0, 0, 0);
      tick_frame(f_now, f_after);
      void'(sb.pop_front());
   endtask

   task automatic test_clamp_west();
      exp_t e;
      int seg_n[6];
      int seg_dx[6];
      // walk to x=90, stop, then ramp west so speed is 3 on arriving at x=66
      seg_n  = '{702 - m_x, 1, 24, 141, 1, 16};
      seg_dx = '{1, 0, -1, -1, 0, -1};
      for (int s = 0; s < 6; s++) begin
         keycode[31:0] = (seg_dx[s] > 0) ? 32'h07 : (seg_dx[s] < 0) ? 32'h04 : 32'h00;
         for (int t = 0; t < seg_n[s]; t++) begin
            model_step(seg_dx[s], 0, seg_dx[s] != 0);
            tick_frame(f_now, f_after);
            e = sb.pop_front();
            n_checks++;
            if ({pos_x[11:0], speed[3:0]} !== {12'(e.x), 4'(e.spd)}) begin
               n_errors++;
               $display("FAIL west_seg%0d_tick%0d: x=%0d spd=%0d want x=%0d spd=%0d",
                        s, t, pos_x[11:0], speed[3:0], e.x, e.spd);
            end
         end
      end
      n_checks++;
      if ({pos_x[11:0], speed[3:0], dir[1:0]} !== {12'd66, 4'd3, 2'd3}) begin
         n_errors++;
         $display("FAIL west_approach: x=%0d spd=%0d dir=%0d want 66 3 3",
                  pos_x[11:0], speed[3:0], dir[1:0]);
      end
      for (int t = 0; t < 4; t++) begin
         model_step(-1, 0, 1);
         tick_frame(f_now, f_after);
         void'(sb.pop_front());
         n_checks++;
         if (pos_x[11:0] !== 12'd64) begin
            n_errors++;
            $display("FAIL west_clamp%0d: x=%0d want 64", t, pos_x[11:0]);
         end
      end
      keycode = '0;
      model_step(0, 0, 0);
      tick_frame(f_now, f_after);
      void'(sb.pop_front());
   endtask

   task automatic test_fire_repeat();
      bit exp_f;
      keycode = {32'h0000_0029, 32'h0000_0000};
      for (int t = 1; t <= 40; t++) begin
         fire_sb.push_back((t == 1) || (t == 17) || (t == 33));
         tick_frame(f_now, f_after);
         exp_f = fire_sb.pop_front();
         n_checks++;
         if ({f_now, f_after} !== {exp_f, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL fire_tick%0d: pulse=%b next=%b want pulse=%b0 next=00",
                     t, f_now, f_after, exp_f);
         end
      end
      keycode = '0;
      tick_frame(f_now, f_after);
   endtask

   task automatic test_diag_face();
      exp_t e;
      keycode[31:0] = 32'h0000_4F1A;
      for (int t = 1; t <= 10; t++) begin
         model_step(0, -1, 1);
         tick_frame(f_now, f_after);
         e = sb.pop_front();
         n_checks++;
         if ({pos_x[11:0], pos_y[11:0], speed[3:0], dir[1:0]} !==
             {12'(e.x), 12'(e.y), 4'(e.spd), 2'd2}) begin
            n_errors++;
            $display("FAIL north_faceE_tick%0d: x=%0d y=%0d spd=%0d dir=%0d want x=%0d y=%0d spd=%0d dir=2",
                     t, pos_x[11:0], pos_y[11:0], speed[3:0], dir[1:0], e.x, e.y, e.spd);
         end
      end
      keycode = '0;
      tick_frame(f_now, f_after);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_move_east();
      test_reset_tick();
      test_clamp_west();
      test_fire_repeat();
      test_diag_face();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Generalised multi-player motion/aim/fire controller for the top-down arena game.
- Sits between the keyboard front-ends (USB 4-key rollover, PS/2 4-key rollover, one 32-bit keycode word per player) and the sprite/map renderer.
- Runs on the system clock; game state advances once per frame on a detected frame_clk rising edge.
- Adds over the previous generation:
  - N players.
  - Parametrised key maps and map bounds.
  - Speed ramp (acceleration).
  - Edge clamping instead of move rejection.
  - Fire with per-player cooldown.

Parameters:
NUM_PLAYERS, 2, number of players (1..4)
X_MIN, 64, minimum legal x (12-bit unsigned)
X_MAX, 3136, maximum legal x
Y_MIN, 64, minimum legal y
Y_MAX, 2336, maximum legal y
SPEED_MIN, 1, pixels/frame on first moving frame
SPEED_MAX, 4, speed ceiling (≤15)
ACCEL_FRAMES, 8, moving frames per +1 speed step (≥1)
FIRE_COOLDOWN, 15, frames blocked after a shot (≤255)
INIT_X, {12'd1500,12'd700}, packed 12*NUM_PLAYERS reset x; player 0 in LSBs
INIT_Y, {12'd1400,12'd700}, packed 12*NUM_PLAYERS reset y
KEYMAP, USB WASD/arrows/space for p0, PS/2 equivalents for p1, packed 72*NUM_PLAYERS; per player 9 bytes, LSB first: move-N, move-W, move-S, move-E, face-N, face-S, face-W, face-E, fire

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
frame_clk  in  1  vertical sync, level; rising edge = frame tick
keycode  in  32*NUM_PLAYERS  four 8-bit held keys per player; 8'h00 = empty slot
pos_x  out  12*NUM_PLAYERS  player x
pos_y  out  12*NUM_PLAYERS  player y
dir  out  2*NUM_PLAYERS  facing: 0 N, 1 S, 2 E, 3 W
moving  out  NUM_PLAYERS  movement key held at last tick
speed  out  4*NUM_PLAYERS  current speed
fire  out  NUM_PLAYERS  one-Clk shot pulse

Behaviour:
- Reset: one clock, synchronous active-high. Asserting it mid-frame overrides any tick in that cycle.
- Reset values:
  - pos = INIT_X/INIT_Y.
  - dir = 0.
  - moving = 0.
  - speed = SPEED_MIN.
  - fire = 0.
  - Cooldown and accel counters = 0.
  - frame_clk_d = 1, so no spurious tick if frame_clk is high at release.
- Tick: tick = frame_clk & ~frame_clk_d, where frame_clk_d is registered every Clk.
  - All per-player state updates only in a cycle with tick=1 and Reset=0.
  - Outputs are visible the following cycle (latency 1 Clk from the tick cycle).
- Key match: key k is held if any of the 4 bytes equals KEYMAP byte k. A KEYMAP byte of 00 never matches.
- Displacement:
  - dx = E − W, dy = S − N, each in {−1,0,+1}; opposing keys cancel.
  - moving_next = any move key held.
- Position:
  - next = clamp(pos + d*speed, MIN, MAX), computed 14-bit signed, no wrap.
  - Uses speed before this tick's update.
  - A step that would cross a bound lands exactly on the bound.
- Speed/accel per player:
  - If not moving_next: speed ← SPEED_MIN, acc ← 0.
  - Else if acc == ACCEL_FRAMES−1: acc ← 0, speed ← min(speed+1, SPEED_MAX).
  - Else acc ← acc+1.
- Facing priority, later overrides earlier: move-N, move-W, move-S, move-E, face-N, face-S, face-W, face-E. With no matching key, dir holds.
- Fire:
  - At a tick, if the fire key is held and cooldown == 0: fire pulses high for exactly the next Clk cycle and cooldown ← FIRE_COOLDOWN.
  - Else, if cooldown ≠ 0, it decrements.
  - Holding fire auto-repeats with period FIRE_COOLDOWN+1 frames.
  - fire is never high two consecutive cycles.
- Players are independent; identical keycodes on two players drive both.

Optional Feature:
PLAYER_COLLISION_EN
- Defined:
  - Each player's candidate position is cancelled (pos holds; dir and speed still update) if it lies within Chebyshev distance < 32 of another player's pre-tick position.
  - If two candidates are within < 32 of each other, both are cancelled.
- Undefined: players pass through each other; no comparators are synthesised.

Test Plan:
- Reset release with frame_clk=1, then held high 10 cycles → no tick; pos_x[0]=700, pos_y[0]=700, dir=0, speed=1.
- p0 holds 8'h07 (move-E) for 20 ticks from x=700, defaults → speed 1 for ticks 1–8, 2 for 9–16, 3 for 17–20; x=700+8+16+12=736; dir=2; release → speed=1 at next tick.
- p0 at x=66, holds move-W, speed 3 → x=64 (clamped), not 63 and not held at 66; further ticks stay 64.
- p1 holds fire (8'h29) continuously for 40 ticks, FIRE_COOLDOWN=15 → fire[1] pulses at ticks 1, 17, 33, one Clk wide each.
- p0 holds 8'h1A and 8'h4F together (move-N + face-E) → y decreases by speed, dir=2.
- Reset asserted in the same cycle as a tick while moving → pos returns to INIT, fire=0, cooldown cleared.
